// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory arbiter and its memory.
package data_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  // Defaults shared with data_memory; both sides must agree.
  localparam int DATA_W = 32;
  localparam int ADDR_N = 5;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester ports plus the data_memory control/data bus of the arbiter.
interface data_mem_arbiter_if #(
  parameter int W = 32,
  parameter int N = 5
);
  logic         req0, req1;
  logic         we0, we1;
  logic [N-1:0] addr0, addr1;
  logic [W-1:0] wdata0, wdata1;
  logic         ack0, ack1;
  logic [W-1:0] rdata0, rdata1;
  logic         busy;
  logic [N-1:0] mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [W-1:0] mem_write_data;
  logic [W-1:0] mem_read_data;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    output ack0, ack1, rdata0, rdata1, busy,
           mem_address, mem_read, mem_write, mem_write_data
  );

  // Requesters together with the memory.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    input  ack0, ack1, rdata0, rdata1, busy,
           mem_address, mem_read, mem_write, mem_write_data
  );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not
// win last time is granted.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       gnt
);
  assign valid = |req;
  assign gnt   = (req == 2'b11) ? ~last : req[1];
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares single-port data_memory between the core LSU (port 0) and the
// DMA/debug loader (port 1); one access every three cycles.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int N = ADDR_N
) (
  input logic              clk,
  input logic              rst,
  data_mem_arbiter_if.slave bus
);

  arb_state_t   state, state_nxt;
  logic         last;
  logic         gnt;
  logic         lat_we;
  logic [N-1:0] lat_addr;
  logic [W-1:0] lat_wdata;
  logic         pick_valid;
  logic         pick_gnt;

  rr_pick2 u_pick (
    .req   ({bus.req1, bus.req0}),
    .last  (last),
    .valid (pick_valid),
    .gnt   (pick_gnt)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= PORT_DMA;
      gnt       <= PORT_CORE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) begin
        gnt       <= pick_gnt;
        lat_we    <= (pick_gnt == PORT_DMA) ? bus.we1    : bus.we0;
        lat_addr  <= (pick_gnt == PORT_DMA) ? bus.addr1  : bus.addr0;
        lat_wdata <= (pick_gnt == PORT_DMA) ? bus.wdata1 : bus.wdata0;
      end
      if (state == RESP) last <= gnt;
    end
  end

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced to zero while rst is high, which also suppresses an
  // ack that would otherwise fall in a reset cycle.
  always_comb begin
    bus.ack0           = 1'b0;
    bus.ack1           = 1'b0;
    bus.rdata0         = '0;
    bus.rdata1         = '0;
    bus.busy           = 1'b0;
    bus.mem_address    = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_write_data = '0;
    if (!rst) begin
      bus.busy = (state != IDLE);
      case (state)
        ISSUE: begin
          bus.mem_address    = lat_addr;
          bus.mem_write_data = lat_wdata;
          bus.mem_write      = lat_we;
          bus.mem_read       = ~lat_we;
        end
        RESP: begin
          // read_data was captured by the memory at the ISSUE->RESP edge.
          if (gnt == PORT_DMA) begin
            bus.ack1   = 1'b1;
            bus.rdata1 = lat_we ? '0 : bus.mem_read_data;
          end else begin
            bus.ack0   = 1'b1;
            bus.rdata0 = lat_we ? '0 : bus.mem_read_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
